// File: rtl/r4_butterfly_stream.sv
// Pipelined radix-4 DIT/DIF butterfly: one calc cycle, then X0..X3 streamed out with valid/ready.
// Define R4_BFLY_SCALE_EN to divide every result by 4 (arithmetic shift, rounds toward -inf).
`timescale 1ns/1ps
module r4_butterfly_stream #(
    parameter int W = 8
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         inv,
    input  logic [W-1:0] xr0,
    input  logic [W-1:0] xr1,
    input  logic [W-1:0] xr2,
    input  logic [W-1:0] xr3,
    input  logic [W-1:0] xi0,
    input  logic [W-1:0] xi1,
    input  logic [W-1:0] xi2,
    input  logic [W-1:0] xi3,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W+1:0] out_re,
    output logic [W+1:0] out_im,
    output logic [1:0]   out_idx,
    output logic         out_last,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, CALC, EMIT} state_t;

    state_t state, state_nxt;
    logic [1:0] idx;
    logic       inv_q;
    logic       accept;
    logic       out_fire;

    logic signed [W-1:0] in_re_q [4];
    logic signed [W-1:0] in_im_q [4];
    logic signed [W+1:0] ext_re  [4];
    logic signed [W+1:0] ext_im  [4];
    logic signed [W+1:0] res_re  [4];
    logic signed [W+1:0] res_im  [4];
    logic signed [W+1:0] bank_re [4];
    logic signed [W+1:0] bank_im [4];

    logic signed [W+1:0] s02_re, s02_im, d02_re, d02_im;
    logic signed [W+1:0] s13_re, s13_im, d13_re, d13_im;

    assign accept   = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    function automatic logic signed [W+1:0] scale(input logic signed [W+1:0] v);
`ifdef R4_BFLY_SCALE_EN
        return v >>> 2;
`else
        return v;
`endif
    endfunction

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The idx==3 handshake doubles as the next acceptance slot, so back-to-back blocks skip IDLE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = CALC;
            CALC: state_nxt = EMIT;
            EMIT: if (out_fire && idx == 2'd3) state_nxt = accept ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_re    = '0;
        out_im    = '0;
        out_idx   = '0;
        out_last  = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: in_ready = !wb_rst_i;
            CALC: busy = 1'b1;
            EMIT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_re    = bank_re[idx];
                out_im    = bank_im[idx];
                out_idx   = idx;
                out_last  = (idx == 2'd3);
                in_ready  = !wb_rst_i && (idx == 2'd3) && out_ready;
            end
            default: ;
        endcase
    end

    // Multiplication by +-j is a real/imag swap with one negation, so everything reduces to
    // sums and differences of the a/c and b/d pairs.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            ext_re[n] = {{2{in_re_q[n][W-1]}}, in_re_q[n]};
            ext_im[n] = {{2{in_im_q[n][W-1]}}, in_im_q[n]};
        end
        s02_re = ext_re[0] + ext_re[2];
        s02_im = ext_im[0] + ext_im[2];
        d02_re = ext_re[0] - ext_re[2];
        d02_im = ext_im[0] - ext_im[2];
        s13_re = ext_re[1] + ext_re[3];
        s13_im = ext_im[1] + ext_im[3];
        d13_re = ext_re[1] - ext_re[3];
        d13_im = ext_im[1] - ext_im[3];

        res_re[0] = scale(s02_re + s13_re);
        res_im[0] = scale(s02_im + s13_im);
        res_re[2] = scale(s02_re - s13_re);
        res_im[2] = scale(s02_im - s13_im);
        if (!inv_q) begin
            res_re[1] = scale(d02_re + d13_im);
            res_im[1] = scale(d02_im - d13_re);
            res_re[3] = scale(d02_re - d13_im);
            res_im[3] = scale(d02_im + d13_re);
        end else begin
            res_re[1] = scale(d02_re - d13_im);
            res_im[1] = scale(d02_im + d13_re);
            res_re[3] = scale(d02_re + d13_im);
            res_im[3] = scale(d02_im - d13_re);
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            inv_q <= 1'b0;
            idx   <= '0;
            for (int n = 0; n < 4; n++) begin
                in_re_q[n] <= '0;
                in_im_q[n] <= '0;
                bank_re[n] <= '0;
                bank_im[n] <= '0;
            end
        end else begin
            if (accept) begin
                inv_q      <= inv;
                in_re_q[0] <= xr0;
                in_re_q[1] <= xr1;
                in_re_q[2] <= xr2;
                in_re_q[3] <= xr3;
                in_im_q[0] <= xi0;
                in_im_q[1] <= xi1;
                in_im_q[2] <= xi2;
                in_im_q[3] <= xi3;
            end
            if (state == CALC) begin
                for (int n = 0; n < 4; n++) begin
                    bank_re[n] <= res_re[n];
                    bank_im[n] <= res_im[n];
                end
                idx <= '0;
            end else if (out_fire) begin
                idx <= idx + 2'd1;
            end
        end
    end

endmodule

// File: doc/r4_butterfly_stream.md
# r4_butterfly_stream

Parametrised, pipelined radix-4 DIT/DIF butterfly with a valid/ready streaming interface. It is the next generation of the team's fixed 4-bit combinational radix-4 butterfly. It accepts four complex samples per transaction, computes all four outputs in one registered stage, and emits them serially X0..X3 with backpressure. Forward or inverse transform is selectable per transaction. It sits behind the logic-analyzer/Wishbone glue in the user project wrapper and feeds downstream FFT stages.

## Interface
Parameters:
- `W`, default 8: signed two's-complement width of each input real/imag component.

Ports:
- `wb_clk_i`  in  1  sole clock; all state updates on rising edge.
- `wb_rst_i`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input transaction offered.
- `in_ready`  out  1  block can accept a transaction this cycle.
- `inv`  in  1  sampled with inputs; 0 = forward, 1 = inverse (conjugate twiddles).
- `xr0..xr3`  in  W each  real parts of samples a, b, c, d.
- `xi0..xi3`  in  W each  imaginary parts of samples a, b, c, d.
- `out_valid`  out  1  output word present.
- `out_ready`  in  1  downstream accepts the output word.
- `out_re`, `out_im`  out  W+2 each  signed result component.
- `out_idx`  out  2  index k of the current Xk.
- `out_last`  out  1  high while `out_idx`==3.
- `busy`  out  1  state != IDLE.

## Operation
- Forward: X0=a+b+c+d; X1=a−jb−c+jd; X2=a−b+c−d; X3=a+jb−c−jd. Inverse swaps the X1 and X3 formulas.
- Multiplying by ±j swaps the real and imaginary parts, with one sign negated. There are no multipliers.
- Inputs are sign-extended to W+2 before summing. Results are exact and never overflow.
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid&in_ready`, register all inputs and `inv`, then go to CALC.
  - CALC: one cycle. Compute all four results into the result bank, set idx=0, go to EMIT.
  - EMIT: drive the result bank entry [idx]. On `out_valid&out_ready` with idx<3, increment idx. With idx==3: if `in_valid`, capture the new inputs and go to CALC; otherwise go to IDLE.
- `in_ready` = (state==IDLE) | (state==EMIT & idx==3 & `out_ready`). It is forced to 0 while `wb_rst_i` is high.
- Data presented with `in_valid` low is ignored. Inputs change freely outside the acceptance edge.

## Timing
- Reset values:
  - `out_valid`=0, `out_re`=0, `out_im`=0, `out_idx`=0, `out_last`=0, `busy`=0.
  - State is IDLE and the result bank is cleared.
  - `in_ready` reads 1 from the first cycle after reset deasserts.
- Latency: when inputs are accepted at edge k, X0 is valid after edge k+1.
- Each Xk holds at least one cycle. Minimum transaction period is 5 cycles: 1 CALC plus 4 EMIT.
- While `out_valid`=1 and `out_ready`=0, `out_re`, `out_im` and `out_idx` must remain stable.
- Reset mid-transaction aborts immediately and asynchronously. The partial block is dropped and no further output is produced for it.
- A transaction offered during CALC or at EMIT idx<3 is not accepted; the upstream holds it.

## Configuration
- `R4_BFLY_SCALE_EN`
  - Defined: each result is arithmetically right-shifted by 2 (truncating toward −∞), then sign-extended back to W+2. Output magnitude then matches the input range, which suits cascaded stages.
  - Undefined: results are full-precision (default).
  - Port widths are identical in both builds.

## Test plan
All with W=8.
- Impulse DC: a=b=c=d=(1,0), `inv`=0, `out_ready`=1 -> X0=(4,0), X1=X2=X3=(0,0). X0 appears 2 edges after acceptance and `out_last` is high on X3.
- Twiddle check: a=c=d=0, b=(1,0) -> forward X0=(1,0), X1=(0,−1), X2=(−1,0), X3=(0,1). Repeat with `inv`=1 -> X1=(0,1), X3=(0,−1).
- Extremes: all components −128 -> X0=(−512,−512) with no wrap. With `R4_BFLY_SCALE_EN` -> X0=(−128,−128). Separately, b=(3,0) with scaling -> X0=(0,0) and X2=(−1,0), confirming truncation toward −∞.
- Backpressure: drop `out_ready` for 3 cycles while X2 is shown -> X2 is held stable and `in_ready`=0. The sequence then resumes with X3.
- Back-to-back: two transactions with `in_valid` held high and `out_ready`=1 -> the second is accepted on the X3 handshake edge. Its X0 appears exactly 5 cycles after the first block's X0.
- Reset mid-emit: assert `wb_rst_i` while X1 is shown -> all outputs are 0 immediately. After release, `in_ready`=1 and a fresh block produces the correct results.
